// File: rtl/challengeqsys_timer_sched.sv
// challengeqsys_timer_sched
// Shares one interval-timer slave (16-bit registers: 0 status, 1 control,
// 2 period_l, 3 period_h) among N_REQ requesters that each need a one-shot
// delay. Requests are served round-robin; for each grant the timer is
// cleared, programmed, started as a one-shot with IRQ enabled, and the
// requester gets a one-cycle done pulse once the interrupt arrives.
//
// Ports
//   clk            in   system clock
//   reset          in   synchronous, active-high reset
//   req            in   level request per requester; drop to cancel
//   req_delay      in   delay for requester i in [i*DELAY_W +: DELAY_W]
//   done           out  one-cycle pulse, requester's delay expired
//   busy           out  scheduler is serving a request
//   grant_id       out  index of requester being served
//   tmr_address    out  timer register address
//   tmr_chipselect out  timer chipselect
//   tmr_write_n    out  timer write strobe, active low
//   tmr_writedata  out  timer write data
//   tmr_irq        in   timer interrupt
//
// State        | meaning
// -------------+---------------------------------------------------------
// S_IDLE       | no grant; arbitrate among pending requests
// S_GRANT      | requester latched; zero delay skips the timer
// S_CLR        | write status=0 to drop any stale timeout
// S_WR_PL      | write period_l
// S_WR_PH      | write period_h
// S_SETTLE     | idle cycle so the timer's period reload completes
// S_START      | write control=START|ITO (one-shot)
// S_WAIT       | wait for tmr_irq
// S_ACK        | write status=0 to clear the timeout / irq
// S_DONE       | pulse done for the granted requester
// S_CANCEL     | requester dropped: write control=STOP, ITO off
// S_CANCEL_CLR | clear status after a cancel, no done pulse

module challengeqsys_timer_sched #(
    parameter int N_REQ   = 4,
    parameter int DELAY_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*DELAY_W-1:0] req_delay,
    output logic [N_REQ-1:0]         done,
    output logic                     busy,
    output logic [2:0]               grant_id,
    output logic [2:0]               tmr_address,
    output logic                     tmr_chipselect,
    output logic                     tmr_write_n,
    output logic [15:0]              tmr_writedata,
    input  logic                     tmr_irq
);

    typedef enum logic [3:0] {
        S_IDLE, S_GRANT, S_CLR, S_WR_PL, S_WR_PH, S_SETTLE, S_START,
        S_WAIT, S_ACK, S_DONE, S_CANCEL, S_CANCEL_CLR
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        rr_q, rr_d;
    logic [2:0]        grant_q, grant_d;
    logic [31:0]       delay_q, delay_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic              busy_q, busy_d;
    logic [2:0]        addr_q, addr_d;
    logic              cs_q, cs_d;
    logic              wn_q, wn_d;
    logic [15:0]       wdata_q, wdata_d;

    logic [7:0]        req_pad;
    logic              found;
    logic [2:0]        pick;
    logic [31:0]       pick_delay;
    logic              req_own;
    logic [2:0]        rr_next;

    // Sums of two indices below N_REQ never reach 2*N_REQ, so one
    // conditional subtract is enough for the modulo.
    function automatic logic [2:0] wrap_idx(input int s);
        return 3'((s >= N_REQ) ? s - N_REQ : s);
    endfunction

    always_comb begin
        req_pad = '0;
        req_pad[N_REQ-1:0] = req;
        found = 1'b0;
        pick  = rr_q;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_pad[wrap_idx(int'(rr_q) + k)]) begin
                found = 1'b1;
                pick  = wrap_idx(int'(rr_q) + k);
            end
        end
        pick_delay = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pick == 3'(k)) begin
                pick_delay = 32'(req_delay[k*DELAY_W +: DELAY_W]);
            end
        end
        req_own = req_pad[grant_q];
        rr_next = wrap_idx(int'(grant_q) + 1);
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        delay_d = delay_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    delay_d = pick_delay;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (delay_q != '0) begin
                    state_d = S_CLR;
                end else if (req_own) begin
                    state_d = S_DONE;
                end else begin
                    rr_d    = rr_next;
                    state_d = S_IDLE;
                end
            end
            S_CLR: begin
                if (req_own) begin
                    state_d = S_WR_PL;
                end else begin
                    rr_d    = rr_next;
                    state_d = S_IDLE;
                end
            end
            S_WR_PL:  state_d = req_own ? S_WR_PH  : S_CANCEL;
            S_WR_PH:  state_d = req_own ? S_SETTLE : S_CANCEL;
            S_SETTLE: state_d = req_own ? S_START  : S_CANCEL;
            S_START:  state_d = req_own ? S_WAIT   : S_CANCEL;
            S_WAIT: begin
                // A drop in the same cycle as the irq still cancels.
                if (!req_own) begin
                    state_d = S_CANCEL;
                end else if (tmr_irq) begin
                    state_d = S_ACK;
                end
            end
            S_ACK:    state_d = S_DONE;
            S_DONE: begin
                rr_d    = rr_next;
                state_d = S_IDLE;
            end
            S_CANCEL: state_d = S_CANCEL_CLR;
            S_CANCEL_CLR: begin
                rr_d    = rr_next;
                state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered strobe
    // lines up with the cycle the FSM spends in the write state.
    always_comb begin
        cs_d    = 1'b0;
        wn_d    = 1'b1;
        addr_d  = 3'd0;
        wdata_d = 16'h0000;
        done_d  = '0;
        busy_d  = (state_d != S_IDLE);
        case (state_d)
            S_CLR, S_ACK, S_CANCEL_CLR: begin
                cs_d = 1'b1;
                wn_d = 1'b0;
            end
            S_WR_PL: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = 3'd2;
                wdata_d = delay_d[15:0];
            end
            S_WR_PH: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = 3'd3;
                wdata_d = delay_d[31:16];
            end
            S_START: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = 3'd1;
                wdata_d = 16'h0005;
            end
            S_CANCEL: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = 3'd1;
                wdata_d = 16'h0008;
            end
            S_DONE: begin
                for (int k = 0; k < N_REQ; k++) begin
                    if (grant_d == 3'(k)) begin
                        done_d[k] = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rr_q    <= 3'd0;
            grant_q <= 3'd0;
            delay_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            addr_q  <= 3'd0;
            cs_q    <= 1'b0;
            wn_q    <= 1'b1;
            wdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            delay_q <= delay_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            addr_q  <= addr_d;
            cs_q    <= cs_d;
            wn_q    <= wn_d;
            wdata_q <= wdata_d;
        end
    end

    assign done           = done_q;
    assign busy           = busy_q;
    assign grant_id       = grant_q;
    assign tmr_address    = addr_q;
    assign tmr_chipselect = cs_q;
    assign tmr_write_n    = wn_q;
    assign tmr_writedata  = wdata_q;

endmodule

// File: tb/tb_challengeqsys_timer_sched.sv
// Testbench for challengeqsys_timer_sched: a behavioural interval-timer model
// answers the write sequence, expected timer writes and done pulses are
// queued by the stimulus and checked as the DUT produces them.

module tb_challengeqsys_timer_sched;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [127:0] req_delay;
    logic [3:0]   done;
    logic         busy;
    logic [2:0]   grant_id;
    logic [2:0]   tmr_address;
    logic         tmr_chipselect;
    logic         tmr_write_n;
    logic [15:0]  tmr_writedata;
    logic         tmr_irq = 1'b0;

    challengeqsys_timer_sched #(.N_REQ(4), .DELAY_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .req_delay      (req_delay),
        .done           (done),
        .busy           (busy),
        .grant_id       (grant_id),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_irq        (tmr_irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Scoreboards: {addr[2:0], data[15:0]} of timer writes, and requester ids of done pulses.
    logic [18:0] wq[$];
    int          dq[$];

    // Timer model state
    logic [31:0] t_per = '0;
    logic [31:0] t_cnt = '0;
    bit          t_run = 0;
    bit          t_to  = 0;
    bit          t_ito = 0;

    int          wr_cnt = 0;
    int          start_cnt = 0;
    int          done_cnt = 0;
    int          last_start_cyc = 0;
    int          last_done_cyc = 0;
    logic [18:0] m_exp;
    int          m_id;

    always @(negedge clk) begin
        if (t_run) begin
            if (t_cnt == 0) begin
                t_to  = 1;
                t_run = 0;
            end else begin
                t_cnt = t_cnt - 1;
            end
        end
        if (tmr_chipselect === 1'b1 && tmr_write_n === 1'b0) begin
            wr_cnt++;
            if (wq.size() == 0) begin
                chk("unexpected_write", {13'b0, tmr_address, tmr_writedata}, 32'hFFFF_FFFF);
            end else begin
                m_exp = wq.pop_front();
                chk("tmr_write", {13'b0, tmr_address, tmr_writedata}, {13'b0, m_exp});
            end
            case (tmr_address)
                3'd0: t_to = 0;
                3'd2: t_per[15:0]  = tmr_writedata;
                3'd3: t_per[31:16] = tmr_writedata;
                3'd1: begin
                    t_ito = tmr_writedata[0];
                    if (tmr_writedata[3]) t_run = 0;
                    if (tmr_writedata[2]) begin
                        t_cnt = t_per;
                        t_run = 1;
                        start_cnt++;
                        last_start_cyc = cyc;
                    end
                end
                default: ;
            endcase
        end
        tmr_irq = t_to & t_ito;
        if (done !== 4'b0000 && reset === 1'b0) begin
            done_cnt++;
            last_done_cyc = cyc;
            if (dq.size() == 0) begin
                chk("unexpected_done", {28'b0, done}, 32'hFFFF_FFFF);
            end else begin
                m_id = dq.pop_front();
                chk("done_onehot", {28'b0, done}, 32'(1) << m_id);
                chk("done_grant_id", {29'b0, grant_id}, 32'(m_id));
            end
        end
    end

    task automatic push_txn(input logic [31:0] d);
        wq.push_back({3'd0, 16'h0000});
        wq.push_back({3'd2, d[15:0]});
        wq.push_back({3'd3, d[31:16]});
        wq.push_back({3'd1, 16'h0005});
        wq.push_back({3'd0, 16'h0000});
    endtask

    task automatic wait_dones(input int target, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt >= target) break;
        end
        chk(tag, done_cnt, target);
    endtask

    task automatic wait_starts(input int target, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (start_cnt >= target) break;
        end
        chk(tag, start_cnt, target);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (busy === 1'b0) break;
        end
        chk(tag, {31'b0, busy}, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_done"},   {28'b0, done}, 0);
        chk({tag, "_busy"},   {31'b0, busy}, 0);
        chk({tag, "_grant"},  {29'b0, grant_id}, 0);
        chk({tag, "_cs"},     {31'b0, tmr_chipselect}, 0);
        chk({tag, "_wn"},     {31'b0, tmr_write_n}, 1);
        chk({tag, "_addr"},   {29'b0, tmr_address}, 0);
        chk({tag, "_wdata"},  {16'b0, tmr_writedata}, 0);
    endtask

    int d0, s0, w0, c0, lat;

    initial begin
        reset = 1'b1;
        req = '0;
        req_delay = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // 1: single request, delay 100
        push_txn(32'd100);
        dq.push_back(0);
        d0 = done_cnt;
        req_delay[0*32 +: 32] = 32'd100;
        req[0] = 1'b1;
        wait_dones(d0 + 1, 300, "t1_done");
        req[0] = 1'b0;
        lat = last_done_cyc - last_start_cyc;
        chk("t1_start_to_done", {31'b0, (lat >= 101 && lat <= 106)}, 1);
        repeat (3) @(negedge clk);
        chk("t1_single_pulse", done_cnt, d0 + 1);
        wait_idle(10, "t1_idle");

        // 4: delay spanning period_h
        push_txn(32'h0001_0000);
        dq.push_back(1);
        d0 = done_cnt;
        req_delay[1*32 +: 32] = 32'h0001_0000;
        req[1] = 1'b1;
        wait_dones(d0 + 1, 70000, "t4_done");
        req[1] = 1'b0;
        lat = last_done_cyc - last_start_cyc;
        chk("t4_start_to_done", {31'b0, (lat >= 65537 && lat <= 65543)}, 1);
        wait_idle(10, "t4_idle");

        // 3: zero delay never touches the timer
        dq.push_back(2);
        d0 = done_cnt;
        w0 = wr_cnt;
        req_delay[2*32 +: 32] = 32'd0;
        c0 = cyc;
        req[2] = 1'b1;
        wait_dones(d0 + 1, 10, "t3_done");
        req[2] = 1'b0;
        chk("t3_req_to_done", {31'b0, ((last_done_cyc - c0) <= 3)}, 1);
        repeat (3) @(negedge clk);
        chk("t3_no_writes", wr_cnt, w0);
        wait_idle(10, "t3_idle");

        // 5: cancel during WAIT, then the same requester is served again
        wq.push_back({3'd0, 16'h0000});
        wq.push_back({3'd2, 16'd1000});
        wq.push_back({3'd3, 16'h0000});
        wq.push_back({3'd1, 16'h0005});
        wq.push_back({3'd1, 16'h0008});
        wq.push_back({3'd0, 16'h0000});
        d0 = done_cnt;
        s0 = start_cnt;
        req_delay[3*32 +: 32] = 32'd1000;
        req[3] = 1'b1;
        wait_starts(s0 + 1, 30, "t5_started");
        repeat (50) @(negedge clk);
        req[3] = 1'b0;
        wait_idle(20, "t5_busy_fall");
        chk("t5_no_done", done_cnt, d0);
        chk("t5_writes_consumed", wq.size(), 0);
        push_txn(32'd5);
        dq.push_back(3);
        req_delay[3*32 +: 32] = 32'd5;
        req[3] = 1'b1;
        wait_dones(d0 + 1, 60, "t5_next_done");
        req[3] = 1'b0;
        wait_idle(10, "t5_idle");

        // 2: all requesting, held through done -> 0,1,2,3,0
        for (int i = 0; i < 4; i++) req_delay[i*32 +: 32] = 32'd10;
        for (int i = 0; i < 5; i++) push_txn(32'd10);
        dq.push_back(0);
        dq.push_back(1);
        dq.push_back(2);
        dq.push_back(3);
        dq.push_back(0);
        d0 = done_cnt;
        req = 4'b1111;
        wait_dones(d0 + 5, 400, "t2_five_dones");
        req = 4'b0000;
        wait_idle(10, "t2_idle");
        chk("t2_writes_consumed", wq.size(), 0);

        // 6: reset during WAIT, then a fresh request replays the sequence
        wq.push_back({3'd0, 16'h0000});
        wq.push_back({3'd2, 16'd500});
        wq.push_back({3'd3, 16'h0000});
        wq.push_back({3'd1, 16'h0005});
        s0 = start_cnt;
        req_delay[1*32 +: 32] = 32'd500;
        req[1] = 1'b1;
        wait_starts(s0 + 1, 30, "t6_started");
        repeat (20) @(negedge clk);
        reset = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        check_reset_outputs("t6_reset");
        reset = 1'b0;
        @(negedge clk);
        push_txn(32'd30);
        dq.push_back(2);
        d0 = done_cnt;
        req_delay[2*32 +: 32] = 32'd30;
        req[2] = 1'b1;
        wait_dones(d0 + 1, 100, "t6_done");
        req[2] = 1'b0;
        wait_idle(10, "t6_idle");

        repeat (5) @(negedge clk);
        chk("final_writes_consumed", wq.size(), 0);
        chk("final_dones_consumed", dq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
